// File: rtl/fir_bus_sequencer.sv
// AHB-Lite master that drives the memory-mapped FIR peripheral: loads coefficient
// sets, pushes samples, polls status and hands back each result with its error flag.
module fir_bus_sequencer #(
    parameter int MAX_POLL = 255
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        coeff_req,
    input  logic [15:0] coeff0,
    input  logic [15:0] coeff1,
    input  logic [15:0] coeff2,
    input  logic [15:0] coeff3,
    output logic        coeff_ready,
    output logic        coeff_done,
    input  logic        sample_valid,
    input  logic [15:0] sample_data,
    output logic        sample_ready,
    output logic        result_valid,
    output logic [15:0] result_data,
    output logic        result_err,
    output logic        bus_err,
    output logic        hsel,
    output logic [3:0]  haddr,
    output logic        hsize,
    output logic [1:0]  htrans,
    output logic        hwrite,
    output logic [15:0] hwdata,
    input  logic [15:0] hrdata,
    input  logic        hresp
);

    typedef enum logic [3:0] {
        IDLE, DONE,
        C_ADDR, C_DATA, CP_ADDR, CP_DATA,
        S_ADDR, S_DATA, S_SET1, S_SET2, SP_ADDR, SP_DATA, R_ADDR, R_DATA
    } state_t;

    state_t      state, state_nx;
    logic [2:0]  idx, idx_nx;
    logic [7:0]  poll_cnt, poll_nx;
    logic        err_pend, err_pend_nx;
    logic        rdy_q;
    logic [15:0] coef_q [4];
    logic [15:0] sample_q;

    logic        coeff_acc, sample_acc, poll_last, data_ph;
    logic        coeff_done_nx, result_valid_nx, bus_err_nx, result_ld;
    logic        hsel_nx, hsize_nx, hwrite_nx;
    logic [3:0]  haddr_nx;
    logic [15:0] hwdata_nx;

    // rdy_q is high exactly while the sequencer sits in IDLE; a pending
    // coefficient request masks the sample side so it always wins a tie.
    assign coeff_ready  = rdy_q;
    assign sample_ready = rdy_q & ~coeff_req;
    assign coeff_acc    = coeff_req & rdy_q;
    assign sample_acc   = sample_valid & sample_ready;
    assign poll_last    = ({1'b0, poll_cnt} + 9'd1) >= 9'(MAX_POLL);
    assign data_ph      = (state == C_DATA) || (state == CP_DATA) || (state == S_DATA) ||
                          (state == SP_DATA) || (state == R_DATA);

    always_comb begin
        state_nx        = state;
        idx_nx          = idx;
        poll_nx         = poll_cnt;
        err_pend_nx     = err_pend;
        coeff_done_nx   = 1'b0;
        result_valid_nx = 1'b0;
        bus_err_nx      = 1'b0;
        result_ld       = 1'b0;
        if (data_ph && hresp) begin
            bus_err_nx = 1'b1;
            state_nx   = DONE;
        end else begin
            case (state)
                IDLE: begin
                    if (coeff_acc) begin
                        idx_nx   = 3'd0;
                        state_nx = C_ADDR;
                    end else if (sample_acc) begin
                        state_nx = S_ADDR;
                    end
                end
                DONE:    state_nx = IDLE;
                C_ADDR:  state_nx = C_DATA;
                C_DATA: begin
                    if (idx == 3'd4) begin
                        poll_nx  = 8'd0;
                        state_nx = CP_ADDR;
                    end else begin
                        idx_nx   = idx + 3'd1;
                        state_nx = C_ADDR;
                    end
                end
                CP_ADDR: state_nx = CP_DATA;
                CP_DATA: begin
                    if (hrdata[7:0] == 8'h00) begin
                        coeff_done_nx = 1'b1;
                        state_nx      = DONE;
                    end else if (poll_last) begin
                        bus_err_nx = 1'b1;
                        state_nx   = DONE;
                    end else begin
                        poll_nx  = poll_cnt + 8'd1;
                        state_nx = CP_ADDR;
                    end
                end
                S_ADDR:  state_nx = S_DATA;
                S_DATA:  state_nx = S_SET1;
                S_SET1:  state_nx = S_SET2;
                S_SET2: begin
                    poll_nx  = 8'd0;
                    state_nx = SP_ADDR;
                end
                SP_ADDR: state_nx = SP_DATA;
                SP_DATA: begin
                    if (!hrdata[0]) begin
                        err_pend_nx = hrdata[8];
                        state_nx    = R_ADDR;
                    end else if (poll_last) begin
                        bus_err_nx = 1'b1;
                        state_nx   = DONE;
                    end else begin
                        poll_nx  = poll_cnt + 8'd1;
                        state_nx = SP_ADDR;
                    end
                end
                R_ADDR:  state_nx = R_DATA;
                R_DATA: begin
                    result_ld       = 1'b1;
                    result_valid_nx = 1'b1;
                    state_nx        = DONE;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    // Bus signals are decoded from the next state so they leave a register.
    always_comb begin
        hsel_nx   = 1'b0;
        haddr_nx  = 4'h0;
        hsize_nx  = 1'b0;
        hwrite_nx = 1'b0;
        hwdata_nx = 16'h0000;
        case (state_nx)
            C_ADDR: begin
                hsel_nx   = 1'b1;
                hwrite_nx = 1'b1;
                haddr_nx  = 4'h6 + {idx_nx, 1'b0};
                hsize_nx  = (idx_nx != 3'd4);
            end
            C_DATA:  hwdata_nx = (idx_nx == 3'd4) ? 16'h0001 : coef_q[idx_nx[1:0]];
            CP_ADDR: begin
                hsel_nx  = 1'b1;
                haddr_nx = 4'hE;
            end
            S_ADDR: begin
                hsel_nx   = 1'b1;
                hwrite_nx = 1'b1;
                haddr_nx  = 4'h4;
                hsize_nx  = 1'b1;
            end
            S_DATA:  hwdata_nx = sample_q;
            SP_ADDR: begin
                hsel_nx  = 1'b1;
                hsize_nx = 1'b1;
            end
            R_ADDR: begin
                hsel_nx  = 1'b1;
                haddr_nx = 4'h2;
                hsize_nx = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state        <= IDLE;
            idx          <= 3'd0;
            poll_cnt     <= 8'd0;
            err_pend     <= 1'b0;
            rdy_q        <= 1'b1;
            coeff_done   <= 1'b0;
            result_valid <= 1'b0;
            result_data  <= 16'h0000;
            result_err   <= 1'b0;
            bus_err      <= 1'b0;
            hsel         <= 1'b0;
            haddr        <= 4'h0;
            hsize        <= 1'b0;
            htrans       <= 2'b00;
            hwrite       <= 1'b0;
            hwdata       <= 16'h0000;
        end else begin
            state        <= state_nx;
            idx          <= idx_nx;
            poll_cnt     <= poll_nx;
            err_pend     <= err_pend_nx;
            rdy_q        <= (state_nx == IDLE);
            coeff_done   <= coeff_done_nx;
            result_valid <= result_valid_nx;
            bus_err      <= bus_err_nx;
            hsel         <= hsel_nx;
            haddr        <= haddr_nx;
            hsize        <= hsize_nx;
            htrans       <= {hsel_nx, 1'b0};
            hwrite       <= hwrite_nx;
            hwdata       <= hwdata_nx;
            if (result_ld) begin
                result_data <= hrdata;
                result_err  <= err_pend;
            end
        end
    end

    // Operand holding registers carry no reset; they are only read after a capture.
    always_ff @(posedge clk) begin
        if (coeff_acc) begin
            coef_q[0] <= coeff0;
            coef_q[1] <= coeff1;
            coef_q[2] <= coeff2;
            coef_q[3] <= coeff3;
        end
        if (sample_acc) sample_q <= sample_data;
    end

endmodule
